// File: rtl/alu_pkg.sv
// Shared arithmetic-unit types: divider result payload and its width.
package alu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef struct packed {
    logic              dz;
    logic              zq;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
  } div_result_t;

  localparam int unsigned DIV_RESULT_W = $bits(div_result_t);

endpackage

// File: rtl/div_result_buffer_if.sv
// Handshake, status and control signals of the divider result buffer.
interface div_result_buffer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
);
  import alu_pkg::*;

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_quotient;
  logic [DATA_W-1:0] in_remainder;
  logic [DATA_W-1:0] in_divisor;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_quotient;
  logic [DATA_W-1:0] out_remainder;
  logic              out_dz;
  logic              out_zq;
  logic              flush;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  dz_count;
  logic              dz_count_clr;

  modport slave (
    input  in_valid, in_quotient, in_remainder, in_divisor, out_ready, flush, dz_count_clr,
    output in_ready, out_valid, out_quotient, out_remainder, out_dz, out_zq, level, dz_count
  );

  modport master (
    output in_valid, in_quotient, in_remainder, in_divisor, out_ready, flush, dz_count_clr,
    input  in_ready, out_valid, out_quotient, out_remainder, out_dz, out_zq, level, dz_count
  );

endinterface

// File: rtl/div_result_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush; read data is
// taken straight from storage at the read pointer.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (level == LVL_W'(DEPTH));
  assign empty_c = (level == '0);
  assign do_push = push && !full_c && !flush;
  assign do_pop  = pop && !empty_c && !flush;
  assign rdata_c = mem[rd_ptr];

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      level <= level + LVL_W'(1);
      else if (do_pop && !do_push) level <= level - LVL_W'(1);
    end
  end

endmodule

// File: rtl/div_result_buffer.sv
// Buffers tagged divider results for the writeback path and counts
// accepted divide-by-zero results.
module div_result_buffer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  div_result_buffer_if.slave  bus
);

  localparam int unsigned     LVL_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  div_result_t             wr_entry;
  div_result_t             head;
  logic [DIV_RESULT_W-1:0] rdata;
  logic [LVL_W-1:0]        lvl;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic [CNT_W-1:0]        dz_cnt;

  always_comb begin
    wr_entry.dz        = (bus.in_divisor == '0);
    wr_entry.zq        = (bus.in_quotient == '0);
    wr_entry.quotient  = bus.in_quotient;
    wr_entry.remainder = bus.in_remainder;
  end

  assign bus.in_ready = !full && !bus.flush && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = !empty && bus.out_ready;

  sync_fifo #(
    .WIDTH (DIV_RESULT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .flush   (bus.flush),
    .wdata   (wr_entry),
    .rdata_c (rdata),
    .level   (lvl),
    .full_c  (full),
    .empty_c (empty)
  );

  // Stale storage must never leak out while the buffer is empty.
  assign head              = empty ? '0 : div_result_t'(rdata);
  assign bus.out_valid     = !empty;
  assign bus.out_quotient  = head.quotient;
  assign bus.out_remainder = head.remainder;
  assign bus.out_dz        = head.dz;
  assign bus.out_zq        = head.zq;
  assign bus.level         = lvl;
  assign bus.dz_count      = dz_cnt;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_cnt <= '0;
    end else if (bus.dz_count_clr) begin
      dz_cnt <= '0;
    end else if (push && wr_entry.dz && (dz_cnt != CNT_MAX)) begin
      dz_cnt <= dz_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_div_result_buffer.sv
// Self-checking bench for div_result_buffer: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_div_result_buffer;
  import alu_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_result_buffer_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  div_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries as {dz, zq, quotient, remainder}.
  bit [2*DATA_W+1:0] mq[$];
  int                mdz = 0;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mdz = 0;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_level", 32'(bus.level), 0);
      chk("rst_dz_count", 32'(bus.dz_count), 0);
    end else begin
      bit                er;
      bit                do_push;
      bit                do_pop;
      bit [2*DATA_W+1:0] h;
      bit [2*DATA_W+1:0] e;
      er = (mq.size() < DEPTH) && !bus.flush;
      h  = (mq.size() != 0) ? mq[0] : '0;
      chk("m_in_ready", 32'(bus.in_ready), 32'(er));
      chk("m_out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      chk("m_level", 32'(bus.level), 32'(mq.size()));
      chk("m_quotient", 32'(bus.out_quotient), 32'(h[2*DATA_W-1:DATA_W]));
      chk("m_remainder", 32'(bus.out_remainder), 32'(h[DATA_W-1:0]));
      chk("m_dz", 32'(bus.out_dz), 32'(h[2*DATA_W+1]));
      chk("m_zq", 32'(bus.out_zq), 32'(h[2*DATA_W]));
      chk("m_dz_count", 32'(bus.dz_count), 32'(mdz));
      do_push = bus.in_valid && er;
      do_pop  = (mq.size() != 0) && bus.out_ready && !bus.flush;
      e = {bus.in_divisor == 0, bus.in_quotient == 0, bus.in_quotient, bus.in_remainder};
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(e);
      end
      if (bus.dz_count_clr)                                       mdz = 0;
      else if (do_push && bus.in_divisor == 0 && mdz < CNT_MAX)   mdz = mdz + 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [7:0] q, input logic [7:0] r, input logic [7:0] b);
    bus.in_valid     = v;
    bus.in_quotient  = q;
    bus.in_remainder = r;
    bus.in_divisor   = b;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    bus.out_ready    = 0;
    bus.flush        = 0;
    bus.dz_count_clr = 0;
    repeat (2) cyc();
    chk("reset_level", 32'(bus.level), 0);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b0;
    cyc();

    // Single push, visible the cycle after acceptance.
    set_in(1, 8'd5, 8'd2, 8'd7);
    cyc();
    set_in(0, 0, 0, 0);
    chk("t1_out_valid", 32'(bus.out_valid), 1);
    chk("t1_quotient", 32'(bus.out_quotient), 5);
    chk("t1_remainder", 32'(bus.out_remainder), 2);
    chk("t1_dz", 32'(bus.out_dz), 0);
    chk("t1_zq", 32'(bus.out_zq), 0);
    chk("t1_level", 32'(bus.level), 1);

    // Three divide-by-zero pushes fill the buffer.
    set_in(1, 0, 0, 0);
    repeat (3) cyc();
    chk("t2_dz_count", 32'(bus.dz_count), 3);
    chk("t2_level", 32'(bus.level), 4);
    set_in(1, 8'd9, 8'd1, 8'd3);
    #1;
    chk("t2_full_in_ready", 32'(bus.in_ready), 0);
    cyc();
    chk("t2_level_hold", 32'(bus.level), 4);

    // Pop while full: no push that cycle, push resumes next cycle.
    bus.out_ready = 1;
    #1;
    chk("t3_pop_in_ready", 32'(bus.in_ready), 0);
    cyc();
    chk("t3_level_after_pop", 32'(bus.level), 3);
    chk("t3_head_dz", 32'(bus.out_dz), 1);
    chk("t3_head_zq", 32'(bus.out_zq), 1);
    chk("t3_in_ready", 32'(bus.in_ready), 1);
    cyc();
    chk("t3_level_push_pop", 32'(bus.level), 3);

    // Flush at level 3 with a dz push offered.
    set_in(1, 0, 0, 0);
    bus.flush = 1;
    cyc();
    bus.flush     = 0;
    bus.out_ready = 0;
    set_in(0, 0, 0, 0);
    chk("t5_level", 32'(bus.level), 0);
    chk("t5_out_valid", 32'(bus.out_valid), 0);
    chk("t5_quotient", 32'(bus.out_quotient), 0);
    chk("t5_remainder", 32'(bus.out_remainder), 0);
    chk("t5_dz", 32'(bus.out_dz), 0);
    chk("t5_zq", 32'(bus.out_zq), 0);
    chk("t5_dz_count", 32'(bus.dz_count), 3);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] q;
      logic [7:0] b;
      q = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      set_in($urandom_range(0, 9) < 7, q, 8'($urandom), b);
      bus.out_ready    = $urandom_range(0, 9) < 6;
      bus.flush        = $urandom_range(0, 31) == 0;
      bus.dz_count_clr = $urandom_range(0, 39) == 0;
      cyc();
    end

    // Counter saturation and clear priority.
    set_in(0, 0, 0, 0);
    bus.flush        = 1;
    bus.dz_count_clr = 1;
    cyc();
    bus.flush        = 0;
    bus.dz_count_clr = 0;
    bus.out_ready    = 1;
    set_in(1, 0, 0, 0);
    repeat (255) cyc();
    chk("t6_dz_255", 32'(bus.dz_count), 255);
    cyc();
    chk("t6_dz_sat", 32'(bus.dz_count), 255);
    bus.dz_count_clr = 1;
    cyc();
    bus.dz_count_clr = 0;
    chk("t6_dz_clr_wins", 32'(bus.dz_count), 0);

    // Asynchronous reset mid-stream.
    bus.out_ready = 0;
    set_in(1, 8'd3, 8'd4, 8'd5);
    repeat (2) cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_level", 32'(bus.level), 0);
    chk("t6_rst_out_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_in_ready", 32'(bus.in_ready), 0);
    set_in(0, 0, 0, 0);
    cyc();
    rst = 1'b0;
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
